md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 mdstartE  in  1  start multiply/divide; Execute-stage decode output.
REQ-004 md_opE  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 flushE  in  1  Execute-stage flush; a start in the same cycle is discarded.
REQ-006 srcaE  in  32  rs operand (multiplicand or dividend).
REQ-007 srcbE  in  32  rt operand (multiplier or divisor).
REQ-008 hiwriteE  in  1  MTHI: load hi from srcaE.
REQ-009 lowriteE  in  1  MTLO: load lo from srcaE.
REQ-010 mdrunE  out  1  unit busy; the hazard logic uses it to stall HI/LO accesses and to zero hilodisable.
REQ-011 hi  out  32  HI register (product high word or remainder).
REQ-012 lo  out  32  LO register (product low word or quotient).
REQ-013 mddone  out  1  one-cycle pulse in the cycle hi/lo first show a new result.

Function
REQ-014 FSM states: IDLE, RUN, FIXUP; mdrunE = (state != IDLE).
REQ-015 IDLE -> RUN when mdstartE=1 and flushE=0.
- Latch |srca| and |srcb| (raw values for unsigned ops), the sign flags and md_opE.
- Clear the 6-bit iteration counter.
REQ-016 RUN lasts exactly 32 cycles with one iteration per cycle.
- Multiply: radix-2 shift-add on a 64-bit {acc, multiplier} register.
- Divide: restoring; shift the partial remainder left, subtract the divisor, set the quotient bit when the result is non-negative.
REQ-017 RUN -> FIXUP when the counter reaches 31; FIXUP -> IDLE after one cycle.
REQ-018 FIXUP writes hi/lo as follows.
- Signed multiply: 64-bit product negated when the operand signs differ.
- Signed divide: quotient negated when signs differ; remainder takes the dividend's sign.
- Unsigned ops: raw result.
REQ-019 Latency: start sampled at edge N gives mdrunE=1 for cycles N+1..N+33; hi/lo are valid and mddone=1 in cycle N+34.
REQ-020 hi/lo hold their previous values throughout RUN and FIXUP.
REQ-021 mdstartE while busy is ignored; the hazard logic guarantees none is issued.
REQ-022 hiwriteE/lowriteE in IDLE update hi/lo at the next edge.
REQ-023 hiwriteE/lowriteE while busy are ignored.
REQ-024 hiwriteE/lowriteE in the same cycle as an accepted start: the write happens, then the result overwrites it at FIXUP.
REQ-025 Divide by zero (no trap): unsigned gives lo=0xFFFFFFFF, hi=dividend; signed applies the REQ-018 fix-up to those raw values.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0x00000000.
REQ-027 mddone=0 in every cycle other than the one named in REQ-019.

Reset
REQ-028 On reset: state=IDLE, counter=0, hi=0, lo=0, mdrunE=0, mddone=0, all operand latches cleared.
REQ-029 Reset mid-operation abandons the computation and returns to IDLE the next cycle; no partial result reaches hi/lo.

Configuration
REQ-030 Macro MD_FAST_MULT_EN.
- Defined: MULT/MULTU compute the product with a single-cycle array multiplier, skip RUN and go IDLE -> FIXUP, so mdrunE is high for 1 cycle and the result is valid at N+2.
- Divide timing is unchanged.
REQ-031 Undefined: all operations use the 34-cycle iterative path of REQ-016..019.

Structure
REQ-032 Shared package md_pkg holds:
- md_opE encodings;
- FSM state encoding;
- MD_ITERS=32;
- DIV0_QUOT=32'hFFFFFFFF.
REQ-033 Sub-module md_step holds the one-iteration combinational datapath (add/shift or subtract/shift, selected by op class); md_unit instances it once and owns the FSM, counter and hi/lo.

Verification
REQ-034 MULT 0xFFFFFFFE x 0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA, mddone at N+34, mdrunE high for 33 cycles.
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100.
REQ-037 Start DIVU 9/4, assert reset at N+10 -> IDLE and hi=lo=0 at N+11; no mddone.
REQ-038 MTHI 0x1234 while busy is ignored; MTHI 0x1234 when idle gives hi=0x1234 next cycle; start with flushE=1 leaves mdrunE=0.
REQ-039 With MD_FAST_MULT_EN, MULT 6 x 7 -> lo=42, hi=0, mddone at N+2.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// FSM state encoding, iteration count and the divide-by-zero quotient.
package md_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_FIXUP = 2'b10
    } md_state_t;

    localparam int          MD_ITERS  = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;

    // Bit 1 of the op code selects the divide class.
    function automatic logic is_div_op(input logic [1:0] op);
        return op[1];
    endfunction

    // Bit 0 clear means the operands are two's complement.
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/md_if.sv
// Execute-stage connection to the multiply/divide unit. The pipeline side
// drives the request and MTHI/MTLO signals; the unit returns busy, hi/lo and
// the completion pulse.
interface md_if;

    logic        mdstartE;
    logic [1:0]  md_opE;
    logic        flushE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        hiwriteE;
    logic        lowriteE;
    logic        mdrunE;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mddone;

    modport master (
        output mdstartE, md_opE, flushE, srcaE, srcbE, hiwriteE, lowriteE,
        input  mdrunE, hi, lo, mddone
    );

    modport slave (
        input  mdstartE, md_opE, flushE, srcaE, srcbE, hiwriteE, lowriteE,
        output mdrunE, hi, lo, mddone
    );

endinterface

// File: rtl/md_step.sv
// One iteration of the iterative datapath on the {acc, low} register pair.
// Multiply: radix-2 shift-add, low holds the multiplier and opb the multiplicand.
// Divide: restoring, acc is the partial remainder, low shifts the dividend out
// and the quotient in, opb is the divisor.
module md_step (
    input  logic        is_div,
    input  logic [31:0] acc,
    input  logic [31:0] low,
    input  logic [31:0] opb,
    output logic [31:0] acc_nxt,
    output logic [31:0] low_nxt
);

    logic [32:0] addend;
    logic [32:0] rem_shift;
    logic [33:0] diff;
    logic        unused_diff_bit;

    assign rem_shift       = {acc, low[31]};
    assign diff            = {1'b0, rem_shift} - {2'b00, opb};
    assign unused_diff_bit = diff[32];

    // Select add/shift or subtract/shift for the current op class.
    always_comb begin
        addend  = 33'd0;
        acc_nxt = 32'd0;
        low_nxt = 32'd0;
        if (is_div) begin
            if (!diff[33]) begin
                acc_nxt = diff[31:0];
                low_nxt = {low[30:0], 1'b1};
            end else begin
                acc_nxt = rem_shift[31:0];
                low_nxt = {low[30:0], 1'b0};
            end
        end else begin
            addend  = low[0] ? ({1'b0, acc} + {1'b0, opb}) : {1'b0, acc};
            acc_nxt = addend[32:1];
            low_nxt = {addend[0], low[31:1]};
        end
    end

endmodule

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit. Operands are reduced to magnitudes on start,
// 32 iterations run through md_step, and the FIXUP cycle applies the sign
// correction and writes hi/lo.
// Optional feature macro MD_FAST_MULT_EN: multiplies use a single-cycle array
// multiplier and go straight from IDLE to FIXUP; divides are unaffected.
module md_unit
    import md_pkg::*;
(
    input logic clk,
    input logic reset,
    md_if.slave bus
);

    md_state_t   state;
    md_op_t      op;
    logic [5:0]  count;
    logic [31:0] acc;
    logic [31:0] low;
    logic [31:0] opb;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        run_q;
    logic        done_q;

    logic        start_ok;
    md_op_t      op_in;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [31:0] step_acc;
    logic [31:0] step_low;
    logic [63:0] prod;
    logic [63:0] prod_fix;
    logic [31:0] quot_raw;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign start_ok = bus.mdstartE & ~bus.flushE;
    assign op_in    = md_op_t'(bus.md_opE);
    assign a_neg    = is_signed_op(bus.md_opE) & bus.srcaE[31];
    assign b_neg    = is_signed_op(bus.md_opE) & bus.srcbE[31];
    assign a_abs    = a_neg ? (32'd0 - bus.srcaE) : bus.srcaE;
    assign b_abs    = b_neg ? (32'd0 - bus.srcbE) : bus.srcbE;

    // Sign flags are only ever set for signed ops, so unsigned results pass raw.
    assign prod     = {acc, low};
    assign prod_fix = (sign_a ^ sign_b) ? (64'd0 - prod) : prod;
    assign quot_raw = (opb == 32'd0) ? DIV0_QUOT : low;
    assign quot_fix = (sign_a ^ sign_b) ? (32'd0 - quot_raw) : quot_raw;
    assign rem_fix  = sign_a ? (32'd0 - acc) : acc;
    assign res_hi   = is_div_op(op) ? rem_fix  : prod_fix[63:32];
    assign res_lo   = is_div_op(op) ? quot_fix : prod_fix[31:0];

`ifdef MD_FAST_MULT_EN
    logic [63:0] fast_prod;
    assign fast_prod = {32'd0, a_abs} * {32'd0, b_abs};
`endif

    md_step u_step (
        .is_div  (is_div_op(op)),
        .acc     (acc),
        .low     (low),
        .opb     (opb),
        .acc_nxt (step_acc),
        .low_nxt (step_low)
    );

    // Control FSM plus operand, iteration and hi/lo registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            op     <= OP_MULT;
            count  <= 6'd0;
            acc    <= 32'd0;
            low    <= 32'd0;
            opb    <= 32'd0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.hiwriteE) hi_q <= bus.srcaE;
                    if (bus.lowriteE) lo_q <= bus.srcaE;
                    if (start_ok) begin
                        op     <= op_in;
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        opb    <= b_abs;
                        count  <= 6'd0;
                        run_q  <= 1'b1;
`ifdef MD_FAST_MULT_EN
                        if (!is_div_op(bus.md_opE)) begin
                            acc   <= fast_prod[63:32];
                            low   <= fast_prod[31:0];
                            state <= S_FIXUP;
                        end else begin
                            acc   <= 32'd0;
                            low   <= a_abs;
                            state <= S_RUN;
                        end
`else
                        acc   <= 32'd0;
                        low   <= a_abs;
                        state <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    acc   <= step_acc;
                    low   <= step_low;
                    count <= count + 6'd1;
                    if (count == 6'(MD_ITERS - 1)) state <= S_FIXUP;
                end
                S_FIXUP: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: begin
                    run_q <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mdrunE = run_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
    assign bus.mddone = done_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed operations with a scoreboard of
// expected hi/lo/latency, plus MTHI/MTLO, flush and mid-operation reset cases.
module tb_md_unit;

    logic clk = 1'b0;
    logic reset;

    md_if bus ();

    md_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    // Reference results computed with the language's own arithmetic.
    function automatic void model(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        logic signed [63:0] sp;
        logic [63:0]        up;
        eh = 32'd0;
        el = 32'd0;
        case (op)
            2'b00: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                {eh, el} = sp;
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                {eh, el} = up;
            end
            2'b10: begin
                if (b == 32'd0) begin
                    el = a[31] ? 32'h00000001 : 32'hFFFFFFFF;
                    eh = a;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    el = 32'h80000000;
                    eh = 32'h00000000;
                end else begin
                    el = $signed(a) / $signed(b);
                    eh = $signed(a) % $signed(b);
                end
            end
            default: begin
                if (b == 32'd0) begin
                    el = 32'hFFFFFFFF;
                    eh = a;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] op);
`ifdef MD_FAST_MULT_EN
        return op[1] ? 34 : 2;
`else
        return 34;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input bit with_mtlo, input int poke_cycle);
        exp_t e;
        int   cycles;
        int   runs;
        e.tag = tag;
        model(op, a, b, e.hi, e.lo);
        e.lat = exp_lat(op);
        sb.push_back(e);

        @(negedge clk);
        bus.md_opE   = op;
        bus.srcaE    = a;
        bus.srcbE    = b;
        bus.mdstartE = 1'b1;
        bus.lowriteE = with_mtlo;
        @(negedge clk);
        bus.mdstartE = 1'b0;
        bus.lowriteE = 1'b0;
        cycles = 1;
        runs   = 0;
        if (with_mtlo) begin
            checkOutput({tag, "_mtlo"}, 64'(bus.lo), 64'(a));
            model_lo = a;
        end
        while (bus.mddone !== 1'b1 && cycles < 200) begin
            if (bus.mdrunE === 1'b1) runs++;
            if (cycles == poke_cycle) begin
                bus.hiwriteE = 1'b1;
                bus.srcaE    = 32'h1234;
            end
            @(negedge clk);
            cycles++;
            if (poke_cycle > 0 && cycles == poke_cycle + 1) begin
                bus.hiwriteE = 1'b0;
                checkOutput({tag, "_mthi_busy"}, 64'(bus.hi), 64'(model_hi));
            end
        end

        e = sb.pop_front();
        checkOutput({e.tag, "_hi"}, 64'(bus.hi), 64'(e.hi));
        checkOutput({e.tag, "_lo"}, 64'(bus.lo), 64'(e.lo));
        checkOutput({e.tag, "_latency"}, 64'(cycles), 64'(e.lat));
        checkOutput({e.tag, "_busy_cycles"}, 64'(runs), 64'(e.lat - 1));
        model_hi = e.hi;
        model_lo = e.lo;
        @(negedge clk);
        checkOutput({e.tag, "_done_once"}, 64'(bus.mddone), 64'd0);
    endtask

    // Directed sequence driving the unit and checking every result.
    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          done_seen;

        reset        = 1'b1;
        bus.mdstartE = 1'b0;
        bus.md_opE   = 2'b00;
        bus.flushE   = 1'b0;
        bus.srcaE    = 32'd0;
        bus.srcbE    = 32'd0;
        bus.hiwriteE = 1'b0;
        bus.lowriteE = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_hi", 64'(bus.hi), 64'd0);
        checkOutput("reset_lo", 64'(bus.lo), 64'd0);
        checkOutput("reset_mdrunE", 64'(bus.mdrunE), 64'd0);
        checkOutput("reset_mddone", 64'(bus.mddone), 64'd0);
        reset    = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        $display("[TB] reset released");

        applyStimulus("mult_neg2x3",   2'b00, 32'hFFFFFFFE, 32'h00000003, 1'b0, 0);
        applyStimulus("multu_max",     2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
        applyStimulus("div_m7_2",      2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b0, 0);
        applyStimulus("divu_100_0",    2'b11, 32'd100,      32'd0,        1'b0, 0);
        applyStimulus("div_ovf",       2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
        applyStimulus("div_m7_0",      2'b10, 32'hFFFFFFF9, 32'd0,        1'b0, 0);
        applyStimulus("mult_6x7",      2'b00, 32'd6,        32'd7,        1'b0, 0);
        applyStimulus("divu_mthi",     2'b11, 32'd9,        32'd4,        1'b0, 5);
        applyStimulus("div_mtlo",      2'b10, 32'd1000,     32'hFFFFFFFD, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            applyStimulus($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 1'b0, 0);
        end

        @(negedge clk);
        bus.hiwriteE = 1'b1;
        bus.srcaE    = 32'h1234;
        @(negedge clk);
        bus.hiwriteE = 1'b0;
        checkOutput("mthi_idle_hi", 64'(bus.hi), 64'h1234);
        checkOutput("mthi_idle_lo", 64'(bus.lo), 64'(model_lo));
        model_hi = 32'h1234;

        @(negedge clk);
        bus.mdstartE = 1'b1;
        bus.flushE   = 1'b1;
        bus.md_opE   = 2'b11;
        bus.srcaE    = 32'd9;
        bus.srcbE    = 32'd4;
        @(negedge clk);
        bus.mdstartE = 1'b0;
        bus.flushE   = 1'b0;
        checkOutput("flush_mdrunE", 64'(bus.mdrunE), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("flush_mdrunE_later", 64'(bus.mdrunE), 64'd0);
        checkOutput("flush_hi_kept", 64'(bus.hi), 64'(model_hi));

        @(negedge clk);
        bus.mdstartE = 1'b1;
        bus.md_opE   = 2'b11;
        bus.srcaE    = 32'd9;
        bus.srcbE    = 32'd4;
        @(negedge clk);
        bus.mdstartE = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midrst_mdrunE", 64'(bus.mdrunE), 64'd0);
        checkOutput("midrst_hi", 64'(bus.hi), 64'd0);
        checkOutput("midrst_lo", 64'(bus.lo), 64'd0);
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.mddone === 1'b1) done_seen = 1'b1;
        end
        checkOutput("midrst_no_done", 64'(done_seen), 64'd0);
        checkOutput("midrst_hi_later", 64'(bus.hi), 64'd0);
        checkOutput("midrst_lo_later", 64'(bus.lo), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
